// File: rtl/imem_boot_loader_if.sv
// Byte-stream and instruction-memory write bundle for imem_boot_loader.
// The slave modport is the loader; the master modport is the byte source / memory side.
interface imem_boot_loader_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;

    modport master (
        output rx_valid,
        output rx_data,
        input  rx_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );

    modport slave (
        input  rx_valid,
        input  rx_data,
        output rx_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );
endinterface

// File: rtl/imem_boot_loader.sv
// Framed byte-stream boot loader: MAGIC, LEN, (LEN+1) big-endian words, written to imem.
// Optional IMEM_LOADER_CHECKSUM_EN adds a trailing XOR check byte that gates the core release.
module imem_boot_loader #(
    parameter int unsigned ADDR_W = 8,
    parameter logic [7:0]  MAGIC  = 8'hA5
) (
    input  logic              clk,
    input  logic              reset_n,
    imem_boot_loader_if.slave bus,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error
);
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN  = 3'd1,
        HI   = 3'd2,
        LO   = 3'd3,
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHK  = 3'd4,
`endif
        DONE = 3'd5,
        ERR  = 3'd6
    } state_t;

    localparam int unsigned CAP_M1 = (1 << ADDR_W) - 1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic [7:0]        hi_q, hi_d;
    logic              we_d;
    logic [ADDR_W-1:0] addr_d;
    logic [15:0]       wdata_d;
    logic              hold_d, done_d, err_d, busy_d;
    logic              fire;
    logic              len_ovf;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        xor_q, xor_d;
`endif

    assign fire    = bus.rx_valid && bus.rx_ready;
    // LEN+1 words must fit in 2^ADDR_W; only reachable when ADDR_W < 8
    assign len_ovf = (32'(bus.rx_data) > CAP_M1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        hi_d    = hi_q;
        we_d    = 1'b0;
        addr_d  = bus.mem_addr;
        wdata_d = bus.mem_wdata;
        hold_d  = cpu_hold;
        done_d  = done;
        err_d   = error;
`ifdef IMEM_LOADER_CHECKSUM_EN
        xor_d   = xor_q;
`endif
        if (fire) begin
            case (state_q)
                IDLE, DONE, ERR: begin
                    if (bus.rx_data == MAGIC) begin
                        state_d = LEN;
                        done_d  = 1'b0;
                        err_d   = 1'b0;
                        hold_d  = 1'b1;
                        cnt_d   = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        xor_d   = '0;
`endif
                    end
                end
                LEN: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    xor_d = xor_q ^ bus.rx_data;
`endif
                    if (len_ovf) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end else begin
                        last_d  = ADDR_W'(bus.rx_data);
                        state_d = HI;
                    end
                end
                HI: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    xor_d = xor_q ^ bus.rx_data;
`endif
                    hi_d    = bus.rx_data;
                    state_d = LO;
                end
                LO: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    xor_d = xor_q ^ bus.rx_data;
`endif
                    we_d    = 1'b1;
                    addr_d  = cnt_q;
                    wdata_d = {hi_q, bus.rx_data};
                    // counter stops on the last word so it never wraps past capacity
                    if (cnt_q == last_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d = CHK;
`else
                        state_d = DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
`endif
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = HI;
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                CHK: begin
                    if (bus.rx_data == xor_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end
                end
`endif
                default: state_d = IDLE;
            endcase
        end
        busy_d = state_d inside {LEN, HI, LO};
`ifdef IMEM_LOADER_CHECKSUM_EN
        busy_d = busy_d || (state_d == CHK);
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            last_q        <= '0;
            hi_q          <= '0;
            bus.rx_ready  <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            cpu_hold      <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            last_q        <= last_d;
            hi_q          <= hi_d;
            bus.rx_ready  <= 1'b1;
            bus.mem_we    <= we_d;
            bus.mem_addr  <= addr_d;
            bus.mem_wdata <= wdata_d;
            cpu_hold      <= hold_d;
            busy          <= busy_d;
            done          <= done_d;
            error         <= err_d;
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            xor_q <= '0;
        end else begin
            xor_q <= xor_d;
        end
    end
`endif
endmodule
